// File: rtl/rob_multi_commit_pkg.sv
// Shared types for the reorder buffer: op classes, entry payload and class helpers.
// The default depth is ROB_DEPTH. The op class is TYPE_W bits wide.
package rob_multi_commit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned ROB_DEPTH = 16;

  typedef enum logic [TYPE_W-1:0] {
    OP_ALU   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_BR    = 3'd3,
    OP_JALR  = 3'd4
  } op_t;

  typedef struct packed {
    logic             valid;
    logic             done;
    op_t              op;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             pred;
    logic [XLEN-1:0]  val;
  } rob_entry_t;

  // Only these classes may retire in the second commit slot.
  function automatic logic is_alu_ld(input op_t op);
    return (op == OP_ALU) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Commit eligibility for head and head+1.
// Inputs : status fields of the head entry and of the entry behind it.
// Outputs: o_ret_en_c (per-slot retire enable), o_ret_cnt_c (entries retired),
//          o_mispred_c (head is a mispredicted branch that retires now).
module rob_commit_sel
  import rob_multi_commit_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                i_head_valid,
  input  logic                i_head_done,
  input  op_t                 i_head_op,
  input  logic                i_head_pred,
  input  logic                i_head_taken,
  input  logic                i_next_valid,
  input  logic                i_next_done,
  input  op_t                 i_next_op,
  output logic [COMMIT_W-1:0] o_ret_en_c,
  output logic [1:0]          o_ret_cnt_c,
  output logic                o_mispred_c
);

  logic w_ret0;
  logic w_ret1;

  assign w_ret0 = i_head_valid & i_head_done;

  // Second slot pairs only simple ops, so stores/branches/JALR stay in slot 0.
  if (COMMIT_W > 1) begin : g_dual
    assign w_ret1 = w_ret0 & is_alu_ld(i_head_op) &
                    i_next_valid & i_next_done & is_alu_ld(i_next_op);
    assign o_ret_en_c = {w_ret1, w_ret0};
  end else begin : g_single
    assign w_ret1 = 1'b0;
    assign o_ret_en_c = w_ret0;
  end

  assign o_ret_cnt_c = 2'(w_ret0) + 2'(w_ret1);
  assign o_mispred_c = w_ret0 & (i_head_op == OP_BR) & (i_head_taken != i_head_pred);

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order retirement of up to COMMIT_W entries per cycle,
// CDB_PORTS writeback ports and full flush on branch mispredict.
// Ports: clk_in/rst_n_in (async active-low), rdy_in (0 freezes all state),
//        iss_* (issue at tail), wb_* (writebacks), full_out/tail_out (combinational
//        from pointers), cm_* / store_commit / jalr_* / clear_* (registered commit).
// Build option ROB_QUERY_EN adds two combinational operand query ports (q_id/q_ready/q_val).
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter  int unsigned DEPTH     = ROB_DEPTH,
  parameter  int unsigned COMMIT_W  = 2,
  parameter  int unsigned CDB_PORTS = 2,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      iss_valid,
  input  logic [TYPE_W-1:0]         iss_type,
  input  logic [REG_W-1:0]          iss_rd,
  input  logic [XLEN-1:0]           iss_pc,
  input  logic [XLEN-1:0]           iss_imm,
  input  logic                      iss_pred,
  input  logic [CDB_PORTS-1:0]      wb_valid,
  input  logic [CDB_PORTS*IDX_W-1:0] wb_id,
  input  logic [CDB_PORTS*XLEN-1:0] wb_val,
`ifdef ROB_QUERY_EN
  input  logic [2*IDX_W-1:0]        q_id,
  output logic [1:0]                q_ready,
  output logic [2*XLEN-1:0]         q_val,
`endif
  output logic                      full_out,
  output logic [IDX_W-1:0]          tail_out,
  output logic [COMMIT_W-1:0]       cm_valid,
  output logic [COMMIT_W*REG_W-1:0] cm_rd,
  output logic [COMMIT_W*XLEN-1:0]  cm_val,
  output logic [COMMIT_W*IDX_W-1:0] cm_id,
  output logic                      store_commit,
  output logic                      jalr_ready,
  output logic [XLEN-1:0]           jalr_addr,
  output logic                      clear_out,
  output logic [XLEN-1:0]           clear_pc
);

  localparam int unsigned PTR_W = IDX_W + 1;

  rob_entry_t            r_ent [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;

  logic [PTR_W-1:0]      w_count;
  logic [IDX_W-1:0]      w_head_idx;
  logic [IDX_W-1:0]      w_next_idx;
  logic [IDX_W-1:0]      w_tail_idx;
  logic [COMMIT_W-1:0]   w_ret_en;
  logic [1:0]            w_ret_cnt;
  logic                  w_mispred;
  logic                  w_iss_acc;
  logic [XLEN-1:0]       w_redirect;

  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_next_idx = w_head_idx + IDX_W'(1);
  assign w_tail_idx = r_tail[IDX_W-1:0];

  assign full_out   = (w_count >= PTR_W'(DEPTH - 1));
  assign tail_out   = w_tail_idx;

  // A mispredict flush swallows any issue arriving in the same cycle.
  assign w_iss_acc  = iss_valid & ~w_mispred & (w_count != PTR_W'(DEPTH));

  assign w_redirect = r_ent[w_head_idx].val[0] ?
                      (r_ent[w_head_idx].pc + r_ent[w_head_idx].imm) :
                      (r_ent[w_head_idx].pc + XLEN'(4));

  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
    .i_head_valid (r_ent[w_head_idx].valid),
    .i_head_done  (r_ent[w_head_idx].done),
    .i_head_op    (r_ent[w_head_idx].op),
    .i_head_pred  (r_ent[w_head_idx].pred),
    .i_head_taken (r_ent[w_head_idx].val[0]),
    .i_next_valid (r_ent[w_next_idx].valid),
    .i_next_done  (r_ent[w_next_idx].done),
    .i_next_op    (r_ent[w_next_idx].op),
    .o_ret_en_c   (w_ret_en),
    .o_ret_cnt_c  (w_ret_cnt),
    .o_mispred_c  (w_mispred)
  );

  // Entry array and pointers: retire, writeback, issue, or full flush.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (rdy_in) begin
      if (w_mispred) begin
        for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
        r_head <= '0;
        r_tail <= '0;
      end else begin
        for (int s = 0; s < COMMIT_W; s++) begin
          if (w_ret_en[s]) r_ent[w_head_idx + IDX_W'(s)].valid <= 1'b0;
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (wb_valid[p] && r_ent[wb_id[p*IDX_W +: IDX_W]].valid) begin
            r_ent[wb_id[p*IDX_W +: IDX_W]].done <= 1'b1;
            r_ent[wb_id[p*IDX_W +: IDX_W]].val  <= wb_val[p*XLEN +: XLEN];
          end
        end
        if (w_iss_acc) begin
          r_ent[w_tail_idx] <= '{valid: 1'b1, done: 1'b0, op: op_t'(iss_type),
                                 rd: iss_rd, pc: iss_pc, imm: iss_imm,
                                 pred: iss_pred, val: '0};
        end
        r_head <= r_head + PTR_W'(w_ret_cnt);
        r_tail <= r_tail + PTR_W'(w_iss_acc);
      end
    end
  end

  // Registered commit outputs; they hold while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cm_valid     <= '0;
      cm_rd        <= '0;
      cm_val       <= '0;
      cm_id        <= '0;
      store_commit <= 1'b0;
      jalr_ready   <= 1'b0;
      jalr_addr    <= '0;
      clear_out    <= 1'b0;
      clear_pc     <= '0;
    end else if (rdy_in) begin
      cm_valid <= w_ret_en;
      for (int s = 0; s < COMMIT_W; s++) begin
        cm_rd[s*REG_W +: REG_W] <= r_ent[w_head_idx + IDX_W'(s)].rd;
        cm_val[s*XLEN +: XLEN]  <= (r_ent[w_head_idx + IDX_W'(s)].op == OP_JALR) ?
                                   (r_ent[w_head_idx + IDX_W'(s)].pc + XLEN'(4)) :
                                   r_ent[w_head_idx + IDX_W'(s)].val;
        cm_id[s*IDX_W +: IDX_W] <= w_head_idx + IDX_W'(s);
      end
      store_commit <= w_ret_en[0] & (r_ent[w_head_idx].op == OP_STORE);
      jalr_ready   <= w_ret_en[0] & (r_ent[w_head_idx].op == OP_JALR);
      jalr_addr    <= r_ent[w_head_idx].val;
      clear_out    <= w_mispred;
      clear_pc     <= w_mispred ? w_redirect : clear_pc;
    end
  end

  // Issuing into a completely full buffer is a protocol violation by the issuer.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in) begin
      assert (!(iss_valid && (w_count == PTR_W'(DEPTH))))
        else $error("rob_multi_commit: issue while ROB holds DEPTH entries");
    end
  end

`ifdef ROB_QUERY_EN
  // Operand query: entry status plus same-cycle CDB forwarding.
  always_comb begin
    q_ready = '0;
    q_val   = '0;
    for (int q = 0; q < 2; q++) begin
      q_ready[q]             = r_ent[q_id[q*IDX_W +: IDX_W]].valid &
                               r_ent[q_id[q*IDX_W +: IDX_W]].done;
      q_val[q*XLEN +: XLEN]  = r_ent[q_id[q*IDX_W +: IDX_W]].val;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (wb_valid[p] && (wb_id[p*IDX_W +: IDX_W] == q_id[q*IDX_W +: IDX_W]) &&
            r_ent[q_id[q*IDX_W +: IDX_W]].valid) begin
          q_ready[q]            = 1'b1;
          q_val[q*XLEN +: XLEN] = wb_val[p*XLEN +: XLEN];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit (DEPTH=16, COMMIT_W=2, CDB_PORTS=2).
module tb_rob_multi_commit;
  import rob_multi_commit_pkg::*;

  localparam int unsigned IDX_W = 4;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        iss_valid;
  logic [TYPE_W-1:0] iss_type;
  logic [4:0]  iss_rd;
  logic [31:0] iss_pc;
  logic [31:0] iss_imm;
  logic        iss_pred;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [63:0] wb_val;
  logic        full_out;
  logic [3:0]  tail_out;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_rd;
  logic [63:0] cm_val;
  logic [7:0]  cm_id;
  logic        store_commit;
  logic        jalr_ready;
  logic [31:0] jalr_addr;
  logic        clear_out;
  logic [31:0] clear_pc;

  int n_tests = 0;
  int n_fail  = 0;

  rob_multi_commit #(.DEPTH(16), .COMMIT_W(2), .CDB_PORTS(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .iss_valid(iss_valid), .iss_type(iss_type), .iss_rd(iss_rd),
    .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_pred(iss_pred),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
    .full_out(full_out), .tail_out(tail_out),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_id(cm_id),
    .store_commit(store_commit), .jalr_ready(jalr_ready), .jalr_addr(jalr_addr),
    .clear_out(clear_out), .clear_pc(clear_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_type = OP_ALU; iss_rd = '0; iss_pc = '0;
    iss_imm = '0; iss_pred = 1'b0; wb_valid = '0; wb_id = '0; wb_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in   = 1'b1;
    rst_n_in = 1'b0;
    repeat (2) step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic issue(input op_t op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    iss_valid = 1'b1; iss_type = op; iss_rd = rd; iss_pc = pc;
    iss_imm = imm; iss_pred = pred;
    step();
    iss_valid = 1'b0;
  endtask

  task automatic wb0(input logic [3:0] id, input logic [31:0] val);
    wb_valid = 2'b01; wb_id = {4'd0, id}; wb_val = {32'd0, val};
    step();
    wb_valid = '0;
  endtask

  initial begin
    do_reset();
    chk("rst_cm_valid", 64'(cm_valid), 64'd0);
    chk("rst_full",     64'(full_out), 64'd0);
    chk("rst_tail",     64'(tail_out), 64'd0);
    chk("rst_clear",    64'(clear_out), 64'd0);
    chk("rst_store",    64'(store_commit), 64'd0);
    chk("rst_jalr",     64'(jalr_ready), 64'd0);

    // T1: out-of-order writebacks, dual retirement then single
    issue(OP_ALU, 5'd1, 32'h0, 32'h0, 1'b0);
    issue(OP_ALU, 5'd2, 32'h4, 32'h0, 1'b0);
    issue(OP_ALU, 5'd3, 32'h8, 32'h0, 1'b0);
    chk("t1_tail", 64'(tail_out), 64'd3);
    wb0(4'd2, 32'h22);
    chk("t1_wait_a", 64'(cm_valid), 64'd0);
    wb0(4'd1, 32'h11);
    chk("t1_wait_b", 64'(cm_valid), 64'd0);
    wb0(4'd0, 32'h10);
    chk("t1_wait_c", 64'(cm_valid), 64'd0);
    step();
    chk("t1_dual_valid", 64'(cm_valid), 64'b11);
    chk("t1_dual_rd",    64'(cm_rd), 64'({5'd2, 5'd1}));
    chk("t1_dual_val",   cm_val, {32'h11, 32'h10});
    chk("t1_dual_id",    64'(cm_id), 64'({4'd1, 4'd0}));
    step();
    chk("t1_single_valid", 64'(cm_valid), 64'b01);
    chk("t1_single_rd",    64'(cm_rd[4:0]), 64'd3);
    chk("t1_single_val",   64'(cm_val[31:0]), 64'h22);
    chk("t1_single_id",    64'(cm_id[3:0]), 64'd2);
    step();
    chk("t1_idle", 64'(cm_valid), 64'd0);

    // T2: fill to DEPTH-1, retire one, tail wraps
    do_reset();
    for (int i = 0; i < 14; i++) issue(OP_ALU, 5'd5, 32'(i * 4), 32'h0, 1'b0);
    chk("t2_not_full_14", 64'(full_out), 64'd0);
    issue(OP_ALU, 5'd5, 32'h38, 32'h0, 1'b0);
    chk("t2_full_15", 64'(full_out), 64'd1);
    chk("t2_tail_15", 64'(tail_out), 64'd15);
    wb0(4'd0, 32'h5);
    chk("t2_full_after_wb", 64'(full_out), 64'd1);
    step();
    chk("t2_retire_valid", 64'(cm_valid), 64'b01);
    chk("t2_retire_id",    64'(cm_id[3:0]), 64'd0);
    chk("t2_full_drop",    64'(full_out), 64'd0);
    issue(OP_ALU, 5'd6, 32'h3c, 32'h0, 1'b0);
    chk("t2_tail_wrap", 64'(tail_out), 64'd0);
    chk("t2_full_again", 64'(full_out), 64'd1);

    // T3: taken mispredict flushes, issue in the flush cycle is dropped
    do_reset();
    issue(OP_BR, 5'd0, 32'h100, 32'h20, 1'b0);
    issue(OP_ALU, 5'd4, 32'h104, 32'h0, 1'b0);
    wb0(4'd0, 32'h1);
    iss_valid = 1'b1; iss_type = OP_ALU; iss_rd = 5'd9;
    wb_valid = 2'b01; wb_id = {4'd0, 4'd1}; wb_val = {32'd0, 32'h5};
    step();
    idle_inputs();
    chk("t3_clear",     64'(clear_out), 64'd1);
    chk("t3_clear_pc",  64'(clear_pc), 64'h120);
    chk("t3_br_valid",  64'(cm_valid), 64'b01);
    chk("t3_tail_zero", 64'(tail_out), 64'd0);
    step();
    chk("t3_clear_pulse", 64'(clear_out), 64'd0);
    chk("t3_post_tail",   64'(tail_out), 64'd0);
    chk("t3_post_full",   64'(full_out), 64'd0);
    step();
    chk("t3_flushed_quiet", 64'(cm_valid), 64'd0);
    // not-taken mispredict redirects to pc+4
    issue(OP_BR, 5'd0, 32'h200, 32'h40, 1'b1);
    wb0(4'd0, 32'h0);
    step();
    chk("t3_nt_clear",    64'(clear_out), 64'd1);
    chk("t3_nt_clear_pc", 64'(clear_pc), 64'h204);
    // correctly predicted branch retires silently
    issue(OP_BR, 5'd0, 32'h300, 32'h10, 1'b1);
    wb0(4'd0, 32'h1);
    step();
    chk("t3_ok_valid", 64'(cm_valid), 64'b01);
    chk("t3_ok_clear", 64'(clear_out), 64'd0);

    // T4: store retires alone; rdy_in low holds strobes
    do_reset();
    issue(OP_STORE, 5'd0, 32'h10, 32'h0, 1'b0);
    issue(OP_ALU,   5'd7, 32'h14, 32'h0, 1'b0);
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_val = {32'h77, 32'haa};
    step();
    idle_inputs();
    step();
    chk("t4_store",       64'(store_commit), 64'd1);
    chk("t4_store_valid", 64'(cm_valid), 64'b01);
    chk("t4_store_id",    64'(cm_id[3:0]), 64'd0);
    rdy_in = 1'b0;
    step();
    chk("t4_hold_store", 64'(store_commit), 64'd1);
    chk("t4_hold_valid", 64'(cm_valid), 64'b01);
    chk("t4_hold_id",    64'(cm_id[3:0]), 64'd0);
    rdy_in = 1'b1;
    step();
    chk("t4_add_valid", 64'(cm_valid), 64'b01);
    chk("t4_add_rd",    64'(cm_rd[4:0]), 64'd7);
    chk("t4_add_val",   64'(cm_val[31:0]), 64'h77);
    chk("t4_add_id",    64'(cm_id[3:0]), 64'd1);
    chk("t4_store_off", 64'(store_commit), 64'd0);
    step();
    chk("t4_idle", 64'(cm_valid), 64'd0);

    // T5: JALR
    do_reset();
    issue(OP_JALR, 5'd1, 32'h40, 32'h0, 1'b0);
    wb0(4'd0, 32'h200);
    step();
    chk("t5_jalr_ready", 64'(jalr_ready), 64'd1);
    chk("t5_jalr_addr",  64'(jalr_addr), 64'h200);
    chk("t5_link_val",   64'(cm_val[31:0]), 64'h44);
    chk("t5_link_rd",    64'(cm_rd[4:0]), 64'd1);
    step();
    chk("t5_jalr_pulse", 64'(jalr_ready), 64'd0);

    // T6: async reset with live entries while frozen
    do_reset();
    for (int i = 0; i < 5; i++) issue(OP_ALU, 5'(i + 1), 32'(i * 4), 32'h0, 1'b0);
    wb0(4'd0, 32'h99);
    step();
    chk("t6_pre_valid", 64'(cm_valid), 64'b01);
    chk("t6_pre_tail",  64'(tail_out), 64'd5);
    rdy_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6_async_valid", 64'(cm_valid), 64'd0);
    chk("t6_async_tail",  64'(tail_out), 64'd0);
    chk("t6_async_rd",    64'(cm_rd), 64'd0);
    chk("t6_async_val",   cm_val, 64'd0);
    #2 rst_n_in = 1'b1;
    rdy_in = 1'b1;
    step();
    chk("t6_after_tail",  64'(tail_out), 64'd0);
    chk("t6_after_full",  64'(full_out), 64'd0);
    chk("t6_after_valid", 64'(cm_valid), 64'd0);
    issue(OP_ALU, 5'd2, 32'h0, 32'h0, 1'b0);
    chk("t6_reissue_tail", 64'(tail_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
